// File: rtl/pipeline_stall_controller.sv
// Prioritised stall/flush sequencer: enables are decoded combinationally from state + hazard inputs,
// with zero latency; a dmem wait freezes the pipe, and an over-long wait halts it until reset.
module pipeline_stall_controller #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             ID_EX_MemRead_i,
  input  logic [4:0]       ID_EX_RegisterRd_i,
  input  logic [4:0]       IF_ID_RS_i,
  input  logic [4:0]       IF_ID_RT_i,
  input  logic             branch_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             pipe_freeze_o,
  output logic             mem_error_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int unsigned WC_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_HALT     = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WC_W-1:0]  r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_mem_error;

  logic w_active;
  logic w_mem_stall;
  logic w_load_use;
  logic w_br_flush;
  logic w_timeout;

  always_comb begin
    w_active    = (r_state == S_RUN) || (r_state == S_MEM_WAIT);
    w_mem_stall = w_active && dmem_req_i && !dmem_ack_i;
    w_load_use  = ID_EX_MemRead_i && (ID_EX_RegisterRd_i != 5'd0) &&
                  ((ID_EX_RegisterRd_i == IF_ID_RS_i) || (ID_EX_RegisterRd_i == IF_ID_RT_i));
    w_br_flush  = branch_i && branch_taken_i;
    w_timeout   = (MEM_TIMEOUT != 0) && w_mem_stall && (r_wait_cnt == WC_LAST);

    // IDLE/HALT values: everything held, nops fed into ID/EX
    pc_write_o     = 1'b0;
    if_id_write_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b1;
    pipe_freeze_o  = 1'b1;

    if (w_active) begin
      if (w_mem_stall) begin
        id_ex_bubble_o = 1'b0;
      end else if (w_load_use) begin
        pipe_freeze_o  = 1'b0;
      end else begin
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        if_id_flush_o  = w_br_flush;
        id_ex_bubble_o = 1'b0;
        pipe_freeze_o  = 1'b0;
      end
    end

    w_next = r_state;
    case (r_state)
      S_IDLE:              if (start_i) w_next = S_RUN;
      S_RUN, S_MEM_WAIT: begin
        if (w_timeout)        w_next = S_HALT;
        else if (w_mem_stall) w_next = S_MEM_WAIT;
        else                  w_next = S_RUN;
      end
      S_HALT:              w_next = S_HALT;
      default:             w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
      r_mem_error <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_mem_stall) r_wait_cnt <= r_wait_cnt + 1'b1;
      else             r_wait_cnt <= '0;
      if (w_active && !pc_write_o && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_timeout) r_mem_error <= 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign mem_error_o = r_mem_error;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Randomised + directed bench: a cycle-level reference model queues expected outputs; a negedge monitor compares.
module tb_pipeline_stall_controller;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic       ID_EX_MemRead_i = 1'b0;
  logic [4:0] ID_EX_RegisterRd_i = 5'd0;
  logic [4:0] IF_ID_RS_i = 5'd0;
  logic [4:0] IF_ID_RT_i = 5'd0;
  logic       branch_i = 1'b0;
  logic       branch_taken_i = 1'b0;
  logic       dmem_req_i = 1'b0;
  logic       dmem_ack_i = 1'b0;
  logic       pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o, pipe_freeze_o, mem_error_o;
  logic [3:0] stall_cnt_o;

  always #5 clk_i = ~clk_i;

  pipeline_stall_controller #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .ID_EX_MemRead_i(ID_EX_MemRead_i), .ID_EX_RegisterRd_i(ID_EX_RegisterRd_i),
    .IF_ID_RS_i(IF_ID_RS_i), .IF_ID_RT_i(IF_ID_RT_i),
    .branch_i(branch_i), .branch_taken_i(branch_taken_i),
    .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i),
    .pc_write_o(pc_write_o), .if_id_write_o(if_id_write_o), .if_id_flush_o(if_id_flush_o),
    .id_ex_bubble_o(id_ex_bubble_o), .pipe_freeze_o(pipe_freeze_o),
    .mem_error_o(mem_error_o), .stall_cnt_o(stall_cnt_o)
  );

  typedef struct packed {
    logic       pc;
    logic       ifw;
    logic       fl;
    logic       bub;
    logic       frz;
    logic       err;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: started/halted flags, consecutive unacked-wait length, total stall cycles.
  bit m_running = 0;
  bit m_halted = 0;
  bit m_err = 0;
  int m_wait = 0;
  int m_stalls = 0;

  task automatic apply(input int r, input int st, input int mr, input int rd, input int rs,
                       input int rt, input int br, input int bt, input int rq, input int ak);
    exp_t e;
    bit   ms, lu;
    rst_i = 1'(r);  start_i = 1'(st);
    ID_EX_MemRead_i = 1'(mr); ID_EX_RegisterRd_i = 5'(rd);
    IF_ID_RS_i = 5'(rs); IF_ID_RT_i = 5'(rt);
    branch_i = 1'(br); branch_taken_i = 1'(bt);
    dmem_req_i = 1'(rq); dmem_ack_i = 1'(ak);
    if (r != 0) begin
      m_running = 0; m_halted = 0; m_err = 0; m_wait = 0; m_stalls = 0;
    end
    ms = (rq != 0) && (ak == 0);
    lu = (mr != 0) && (rd[4:0] != 0) && ((rd[4:0] == rs[4:0]) || (rd[4:0] == rt[4:0]));
    e.pc = 0; e.ifw = 0; e.fl = 0; e.bub = 1; e.frz = 1;
    e.err = m_err;
    e.cnt = (m_stalls > 15) ? 4'd15 : m_stalls[3:0];
    if (r == 0 && m_running && !m_halted) begin
      if (ms) begin
        e.bub = 0;
      end else if (lu) begin
        e.frz = 0;
      end else begin
        e.pc = 1; e.ifw = 1; e.bub = 0; e.frz = 0;
        e.fl = (br != 0) && (bt != 0);
      end
    end
    exp_q.push_back(e);
    if (r == 0) begin
      if (m_running && !m_halted) begin
        if (!e.pc) m_stalls++;
        if (ms) begin
          m_wait++;
          if (m_wait == 4) begin m_halted = 1; m_err = 1; end
        end else begin
          m_wait = 0;
        end
      end else if (!m_running && st != 0) begin
        m_running = 1;
      end
    end
    @(posedge clk_i); #1;
  endtask

  exp_t mon_e, mon_a;
  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o, pipe_freeze_o,
               mem_error_o, stall_cnt_o};
      vectors++;
      if (mon_a !== mon_e) begin
        miscompares++;
        $display("FAIL outputs vec %0d t=%0t: got pc/ifw/fl/bub/frz/err=%b%b%b%b%b%b cnt=%0d, expected %b%b%b%b%b%b cnt=%0d",
                 vectors, $time, mon_a.pc, mon_a.ifw, mon_a.fl, mon_a.bub, mon_a.frz, mon_a.err, mon_a.cnt,
                 mon_e.pc, mon_e.ifw, mon_e.fl, mon_e.bub, mon_e.frz, mon_e.err, mon_e.cnt);
      end
    end
  end

  initial begin
    @(posedge clk_i); #1;
    // reset then idle with start low
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // load-use, then Rd=0 no hazard
    apply(0, 0, 1, 8, 8, 0, 0, 0, 0, 0);
    apply(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    // branch flush, then branch masked by load-use on rt, then flush after bubble
    apply(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    apply(0, 0, 1, 5, 1, 5, 1, 1, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    // dmem wait acked on 4th cycle
    repeat (3) apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // timeout into HALT, which ignores start and hazards
    repeat (4) apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) apply(0, 1, 0, 0, 0, 0, 1, 1, 1, 1);
    // saturation of stall count
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (20) apply(0, 0, 1, 3, 3, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // reset in the middle of a memory wait
    repeat (2) apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    apply(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    apply(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 79) == 0 || (m_halted && $urandom_range(0, 7) == 0)) begin
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      end else if ($urandom_range(0, 24) == 0) begin
        int n;
        n = int'($urandom_range(2, 6));
        for (int k = 0; k < n; k++)
          apply(0, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 1)), 1, 0);
      end else begin
        apply(0, int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 2) == 0), int'($urandom_range(0, 1)));
      end
    end

    @(negedge clk_i); #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors never compared, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
